// File: rtl/char_plotter_if.sv
// char_plotter_if
// Purpose: bundles the draw-request handshake, the glyph decoder link and
// the pixel output bus of char_plotter into one interface.
// Signals:
//   req_valid/req_ready, req_char/req_col/req_row/req_fg/req_bg : draw request
//   dec_char -> external glyph decoder, dec_glyph <- 128-bit bitmap
//   x, y, colour, plot, pix_ready : pixel write bus (transfer on plot && pix_ready)
//   busy, done, err : status
// Modports:
//   master : client side (issues requests, supplies glyph bitmap, sinks pixels)
//   slave  : the plotter itself
interface char_plotter_if;
  logic         req_valid;
  logic         req_ready;
  logic [6:0]   req_char;
  logic [4:0]   req_col;
  logic [2:0]   req_row;
  logic [2:0]   req_fg;
  logic [2:0]   req_bg;
  logic [6:0]   dec_char;
  logic [127:0] dec_glyph;
  logic [7:0]   x;
  logic [6:0]   y;
  logic [2:0]   colour;
  logic         plot;
  logic         pix_ready;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output req_valid, req_char, req_col, req_row, req_fg, req_bg,
    output dec_glyph, pix_ready,
    input  req_ready, dec_char, x, y, colour, plot, busy, done, err
  );

  modport slave (
    input  req_valid, req_char, req_col, req_row, req_fg, req_bg,
    input  dec_glyph, pix_ready,
    output req_ready, dec_char, x, y, colour, plot, busy, done, err
  );
endinterface

// File: rtl/char_plotter.sv
// char_plotter
// Purpose: draws one 8x16 character cell into a 160x120 pixel space. A request
// is latched, the glyph bitmap for the character is fetched from an external
// combinational decoder, then the 128 pixels are emitted row by row, left to
// right, each one waiting for the pixel sink to accept it.
// Parameters:
//   CELL_COLS : number of character columns (default 20)
//   CELL_ROWS : number of character rows (default 7)
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : char_plotter_if.slave (request, decoder link, pixel bus, status)
// Configuration:
//   CHAR_PLOTTER_TRANSPARENT_EN : when defined, background pixels are skipped
//   (no plot) at one per cycle instead of being written with the bg colour.
module char_plotter #(
  parameter int CELL_COLS = 20,
  parameter int CELL_ROWS = 7
) (
  input logic           clk,
  input logic           reset,
  char_plotter_if.slave bus
);

  localparam logic [5:0] COL_LIMIT = 6'(CELL_COLS);
  localparam logic [3:0] ROW_LIMIT = 4'(CELL_ROWS);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t       state;
  state_t       state_next;

  logic [6:0]   dec_char_q;
  logic [4:0]   col_q;
  logic [2:0]   row_q;
  logic [2:0]   fg_q;
  logic [2:0]   bg_q;
  logic [127:0] glyph_q;
  logic [6:0]   pix_idx;
  logic         err_q;

  logic         accept;
  logic         xfer;
  logic         plot_c;
  logic         pix_bit;
  logic         out_of_range;

  // Range check runs on the latched cell so it is valid during LOAD.
  assign out_of_range = ({1'b0, col_q} >= COL_LIMIT) || ({1'b0, row_q} >= ROW_LIMIT);

  // Pixel p lives at bit 127-p: row-major, MSB of each row byte is leftmost.
  assign pix_bit = glyph_q[7'd127 - pix_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // xfer means the current pixel index is consumed this cycle; in transparent
  // mode background pixels are consumed without waiting for the sink.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    xfer       = 1'b0;
    plot_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = out_of_range ? DONE : DRAW;
      end
      DRAW: begin
`ifdef CHAR_PLOTTER_TRANSPARENT_EN
        plot_c = pix_bit;
        xfer   = pix_bit ? bus.pix_ready : 1'b1;
`else
        plot_c = 1'b1;
        xfer   = bus.pix_ready;
`endif
        if (xfer && (pix_idx == 7'd127)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, glyph capture and pixel index. The index is only reset in
  // LOAD; the increment past 127 is harmless because DRAW is left that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_char_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      glyph_q    <= '0;
      pix_idx    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        dec_char_q <= bus.req_char;
        col_q      <= bus.req_col;
        row_q      <= bus.req_row;
        fg_q       <= bus.req_fg;
        bg_q       <= bus.req_bg;
      end
      if (state == LOAD) begin
        glyph_q <= bus.dec_glyph;
        pix_idx <= '0;
        err_q   <= out_of_range;
      end else if (xfer) begin
        pix_idx <= pix_idx + 7'd1;
      end
    end
  end

  // Cells are 8 and 16 pixels, so the coordinates are plain concatenations.
  assign bus.x         = {col_q, pix_idx[2:0]};
  assign bus.y         = {row_q, pix_idx[6:3]};
  assign bus.colour    = pix_bit ? fg_q : bg_q;
  assign bus.plot      = plot_c;
  assign bus.dec_char  = dec_char_q;
  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.err       = (state == DONE) && err_q;

endmodule

// File: tb/tb_char_plotter.sv
// tb_char_plotter
// Purpose: self-checking bench for char_plotter. A glyph ROM model drives
// dec_glyph; a pixel-list model built from the cell geometry predicts every
// pixel; a negedge compare process checks the pixel bus against it, and
// directed tests pin latencies, boundaries, reset abort and handshake rules.
// Honors CHAR_PLOTTER_TRANSPARENT_EN the same way as the design.
module tb_char_plotter;

  localparam int CELL_COLS = 20;
  localparam int CELL_ROWS = 7;
`ifdef CHAR_PLOTTER_TRANSPARENT_EN
  localparam int ABORT_AT = 10;
`else
  localparam int ABORT_AT = 60;
`endif

  typedef struct {
    int x;
    int y;
    int colour;
  } pix_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  char_plotter_if bus();

  char_plotter #(
    .CELL_COLS(CELL_COLS),
    .CELL_ROWS(CELL_ROWS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  pix_t exp_q[$];
  pix_t log_q[$];
  int   exp_total;
  int   xfer_count;
  int   first_lat;
  int   done_lat;
  int   ready_lat;
  int   done_count;
  int   done_err;
  int   acc_cyc;
  int   hold_x;
  int   hold_y;
  bit   done_seen;

  // Small font: space blank, 'A' and 'I' hand drawn, everything else a
  // deterministic scramble of the code so each character looks different.
  function automatic logic [127:0] glyph_of(input logic [6:0] code);
    logic [127:0] g;
    g = '0;
    case (code)
      7'd32: g = '0;
      7'd65: g = {8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 64'h0};
      7'd73: for (int r = 0; r < 16; r++) g[127-8*r -: 8] = 8'h10;
      default: for (int r = 0; r < 16; r++) g[127-8*r -: 8] = 8'(int'(code) * (r + 3)) ^ 8'(r * 29);
    endcase
    return g;
  endfunction

  assign bus.dec_glyph = glyph_of(bus.dec_char);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Expected pixel list straight from the cell geometry.
  task automatic buildExpected(input logic [6:0] ch, input int col, input int row,
                               input int fg, input int bg);
    logic [127:0] g;
    pix_t e;
    g = glyph_of(ch);
    exp_q.delete();
    if (col < CELL_COLS && row < CELL_ROWS) begin
      for (int p = 0; p < 128; p++) begin
        e.x = col * 8 + p % 8;
        e.y = row * 16 + p / 8;
        e.colour = g[127-p] ? fg : bg;
`ifdef CHAR_PLOTTER_TRANSPARENT_EN
        if (g[127-p]) exp_q.push_back(e);
`else
        exp_q.push_back(e);
`endif
      end
    end
    exp_total = exp_q.size();
  endtask

  task automatic clearTrack();
    log_q.delete();
    xfer_count = 0;
    first_lat  = -1;
    done_lat   = -1;
    ready_lat  = -1;
    done_count = 0;
    done_err   = -1;
    hold_x     = -1;
    hold_y     = -1;
    done_seen  = 1'b0;
  endtask

  // Every cycle out of reset: handshake invariants, pixel bus against the
  // model front, transfer logging and latency bookkeeping.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("ready_is_not_busy", int'(bus.req_ready), int'(!bus.busy));
      checkOutput("err_only_with_done", int'(bus.err & ~bus.done), 0);
      if (bus.plot) begin
        if (first_lat < 0) first_lat = cyc - acc_cyc;
        checkOutput("expected_pixel_available", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          checkOutput("pixel_x", int'(bus.x), exp_q[0].x);
          checkOutput("pixel_y", int'(bus.y), exp_q[0].y);
          checkOutput("pixel_colour", int'(bus.colour), exp_q[0].colour);
          if (bus.pix_ready) begin
            pix_t a;
            a.x = int'(bus.x);
            a.y = int'(bus.y);
            a.colour = int'(bus.colour);
            log_q.push_back(a);
            void'(exp_q.pop_front());
            xfer_count++;
          end
        end
      end
      if (bus.done) begin
        done_seen = 1'b1;
        done_lat  = cyc - acc_cyc;
        done_err  = int'(bus.err);
        done_count++;
      end else if (done_seen && ready_lat < 0 && bus.req_ready) begin
        ready_lat = cyc - acc_cyc;
      end
    end
  end

  // Issues one request and returns just after its accept edge.
  task automatic applyStimulus(input logic [6:0] ch, input logic [4:0] col, input logic [2:0] row,
                               input logic [2:0] fg, input logic [2:0] bg, input bit hold_valid);
    int waited;
    buildExpected(ch, int'(col), int'(row), int'(fg), int'(bg));
    clearTrack();
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("ready_before_request", int'(bus.req_ready), 1);
    bus.req_char  = ch;
    bus.req_col   = col;
    bus.req_row   = row;
    bus.req_fg    = fg;
    bus.req_bg    = bg;
    bus.req_valid = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    if (!hold_valid) bus.req_valid = 1'b0;
  endtask

  // Runs the request to done, optionally stalling the sink, pulsing a stray
  // request, or aborting with reset at a given transfer count.
  task automatic waitDone(input int stall_at, input int stall_len, input int abort_at,
                          input int pulse_at, input bit hold_valid);
    int left;
    bit finished;
    bit pulsed;
    left = stall_len;
    finished = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < 400 && !finished; i++) begin
      if (abort_at >= 0 && xfer_count == abort_at) begin
        reset = 1'b1;
        #1;
        checkOutput("abort_plot", int'(bus.plot), 0);
        checkOutput("abort_busy", int'(bus.busy), 0);
        checkOutput("abort_done", int'(bus.done), 0);
        checkOutput("abort_ready", int'(bus.req_ready), 1);
        checkOutput("abort_x", int'(bus.x), 0);
        checkOutput("abort_dec_char", int'(bus.dec_char), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        finished = 1'b1;
      end else if (done_seen) begin
        finished = 1'b1;
      end else begin
        if (stall_at >= 0 && xfer_count == stall_at && left > 0) begin
          bus.pix_ready = 1'b0;
          left--;
          hold_x = int'(bus.x);
          hold_y = int'(bus.y);
        end else begin
          bus.pix_ready = 1'b1;
        end
        if (pulse_at >= 0 && xfer_count == pulse_at && !pulsed) begin
          bus.req_char  = 7'd90;
          bus.req_col   = 5'd0;
          bus.req_valid = 1'b1;
          pulsed = 1'b1;
        end else if (!hold_valid) begin
          bus.req_valid = 1'b0;
        end
        @(posedge clk);
        #1;
      end
    end
    checkOutput("run_finished", int'(finished), 1);
    bus.pix_ready = 1'b1;
  endtask

  function automatic int fgCount(input int fg);
    int n;
    n = 0;
    foreach (log_q[i]) if (log_q[i].colour == fg) n++;
    return n;
  endfunction

  initial begin
    int prev_acc;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_char  = '0;
    bus.req_col   = '0;
    bus.req_row   = '0;
    bus.req_fg    = '0;
    bus.req_bg    = '0;
    bus.pix_ready = 1'b1;
    acc_cyc = 0;
    clearTrack();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", int'(bus.req_ready), 1);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_plot", int'(bus.plot), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_err", int'(bus.err), 0);
    checkOutput("reset_xy", int'({bus.x, bus.y}), 0);
    checkOutput("reset_colour", int'(bus.colour), 0);
    checkOutput("reset_dec_char", int'(bus.dec_char), 0);

    // 'A' at cell (2,1), pending while reset is still high.
    $display("[TB] A at cell 2,1 with request pending across reset release");
    buildExpected(7'd65, 2, 1, 7, 0);
    clearTrack();
    bus.req_char = 7'd65; bus.req_col = 5'd2; bus.req_row = 3'd1;
    bus.req_fg = 3'd7; bus.req_bg = 3'd0; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("pending_ignored_in_reset", int'(bus.busy), 0);
    reset = 1'b0;
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    bus.req_valid = 1'b0;
    checkOutput("accept_first_edge_after_release", int'(bus.busy), 1);
    checkOutput("dec_char_registered", int'(bus.dec_char), 65);
    waitDone(-1, 0, -1, -1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("a_done_lat", done_lat, 130);
    checkOutput("a_ready_lat", ready_lat, 131);
    checkOutput("a_err", done_err, 0);
    checkOutput("a_done_count", done_count, 1);
    checkOutput("a_transfers", log_q.size(), exp_total);
`ifdef CHAR_PLOTTER_TRANSPARENT_EN
    checkOutput("a_first_plot_lat", first_lat, 5);
    checkOutput("a_transfers_literal", log_q.size(), 32);
    checkOutput("a_first_x", log_q.size() > 0 ? log_q[0].x : -1, 19);
    checkOutput("a_first_colour", log_q.size() > 0 ? log_q[0].colour : -1, 7);
`else
    checkOutput("a_first_plot_lat", first_lat, 2);
    checkOutput("a_transfers_literal", log_q.size(), 128);
    if (log_q.size() == 128) begin
      checkOutput("a_p0_x", log_q[0].x, 16);
      checkOutput("a_p0_y", log_q[0].y, 16);
      checkOutput("a_p0_colour", log_q[0].colour, 0);
      checkOutput("a_p11_x", log_q[11].x, 19);
      checkOutput("a_p11_y", log_q[11].y, 17);
      checkOutput("a_p11_colour", log_q[11].colour, 7);
      checkOutput("a_p127_x", log_q[127].x, 23);
      checkOutput("a_p127_y", log_q[127].y, 31);
    end

    // Sink stalls for 5 cycles while pixel 40 is on the bus.
    $display("[TB] A with 5-cycle stall at pixel 40");
    applyStimulus(7'd65, 5'd2, 3'd1, 3'd7, 3'd0, 1'b0);
    waitDone(40, 5, -1, -1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("stall_done_lat", done_lat, 135);
    checkOutput("stall_transfers", log_q.size(), 128);
    checkOutput("stall_hold_x", hold_x, 16);
    checkOutput("stall_hold_y", hold_y, 21);
`endif

    // Out-of-range column and row.
    $display("[TB] out-of-range cells");
    applyStimulus(7'd65, 5'd20, 3'd0, 3'd7, 3'd0, 1'b0);
    waitDone(-1, 0, -1, -1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("col20_done_lat", done_lat, 2);
    checkOutput("col20_err", done_err, 1);
    checkOutput("col20_ready_lat", ready_lat, 3);
    checkOutput("col20_transfers", log_q.size(), 0);
    applyStimulus(7'd66, 5'd0, 3'd7, 3'd1, 3'd2, 1'b0);
    waitDone(-1, 0, -1, -1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("row7_err", done_err, 1);
    checkOutput("row7_done_lat", done_lat, 2);

    // Last valid cell.
    $display("[TB] boundary cell 19,6");
    applyStimulus(7'd66, 5'd19, 3'd6, 3'd3, 3'd5, 1'b0);
    waitDone(-1, 0, -1, -1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("edge_err", done_err, 0);
    checkOutput("edge_done_lat", done_lat, 130);
    checkOutput("edge_transfers", log_q.size(), exp_total);
`ifndef CHAR_PLOTTER_TRANSPARENT_EN
    checkOutput("edge_last_x", log_q.size() == 128 ? log_q[127].x : -1, 159);
    checkOutput("edge_last_y", log_q.size() == 128 ? log_q[127].y : -1, 111);
`endif

    // Space and 'I'.
    $display("[TB] space and I glyphs");
    applyStimulus(7'd32, 5'd5, 3'd3, 3'd2, 3'd4, 1'b0);
    waitDone(-1, 0, -1, -1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("space_done_lat", done_lat, 130);
    checkOutput("space_fg_pixels", fgCount(2), 0);
`ifdef CHAR_PLOTTER_TRANSPARENT_EN
    checkOutput("space_transfers", log_q.size(), 0);
`else
    checkOutput("space_transfers", log_q.size(), 128);
`endif
    applyStimulus(7'd73, 5'd7, 3'd0, 3'd6, 3'd1, 1'b0);
    waitDone(-1, 0, -1, -1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("i_fg_pixels", fgCount(6), 16);
    checkOutput("i_done_lat", done_lat, 130);
`ifdef CHAR_PLOTTER_TRANSPARENT_EN
    checkOutput("i_transfers", log_q.size(), 16);
`else
    checkOutput("i_transfers", log_q.size(), 128);
`endif

    // Reset mid-draw, then a fresh request must restart from pixel 0.
    $display("[TB] reset abort mid-draw");
    applyStimulus(7'd65, 5'd2, 3'd1, 3'd7, 3'd0, 1'b0);
    waitDone(-1, 0, ABORT_AT, -1, 1'b0);
    checkOutput("abort_no_done", done_count, 0);
    applyStimulus(7'd67, 5'd1, 3'd2, 3'd3, 3'd4, 1'b0);
    waitDone(-1, 0, -1, -1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("post_abort_done_lat", done_lat, 130);
    checkOutput("post_abort_transfers", log_q.size(), exp_total);
`ifndef CHAR_PLOTTER_TRANSPARENT_EN
    checkOutput("post_abort_first_plot_lat", first_lat, 2);
    checkOutput("post_abort_p0_x", log_q.size() > 0 ? log_q[0].x : -1, 8);
    checkOutput("post_abort_p0_y", log_q.size() > 0 ? log_q[0].y : -1, 32);
`endif

    // A stray request while busy is dropped, not queued.
    $display("[TB] stray request while busy");
    applyStimulus(7'd65, 5'd3, 3'd2, 3'd1, 3'd6, 1'b0);
    waitDone(-1, 0, -1, 30, 1'b0);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stray_not_queued", int'(bus.busy), 0);
    end
    checkOutput("stray_done_count", done_count, 1);
    checkOutput("stray_transfers", log_q.size(), exp_total);

    // req_valid held high across two requests.
    $display("[TB] back-to-back with req_valid held");
    applyStimulus(7'd65, 5'd4, 3'd3, 3'd5, 3'd2, 1'b1);
    waitDone(-1, 0, -1, -1, 1'b1);
    checkOutput("kv_first_done_lat", done_lat, 130);
    prev_acc = acc_cyc;
    buildExpected(7'd65, 4, 3, 5, 2);
    clearTrack();
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    bus.req_valid = 1'b0;
    checkOutput("kv_accept_gap", acc_cyc - prev_acc, 131);
    checkOutput("kv_second_busy", int'(bus.busy), 1);
    waitDone(-1, 0, -1, -1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("kv_second_done_lat", done_lat, 130);
    checkOutput("kv_second_transfers", log_q.size(), exp_total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
